// File: rtl/reward_weight_updater.sv
`timescale 1ns/1ps
// Read-modify-write sweep that adds a signed reward to every eligible entry of
// the synaptic weight memory, saturating each result to the unsigned weight range.
module reward_weight_updater #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    reward,
    input  logic [DEPTH-1:0] elig_mask,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SW = DW + 2;

    state_t           state, state_nx;
    logic [AW-1:0]    idx, idx_nx;
    logic [DW-1:0]    rew_q;
    logic [DEPTH-1:0] mask_q;
    logic             capture;
    logic             last_idx;
    logic [DW-1:0]    sat_sum;

    assign last_idx = (idx == AW'(DEPTH - 1));

    // Two guard bits hold both the sign of the reward and the carry out of the weight.
    always_comb begin
        logic signed [SW-1:0] sum;
        sum = $signed({2'b00, mem_rdata}) + $signed({{2{rew_q[DW-1]}}, rew_q});
        if (sum[SW-1]) begin
            sat_sum = '0;
        end else if (sum[DW]) begin
            sat_sum = '1;
        end else begin
            sat_sum = sum[DW-1:0];
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        capture   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture  = 1'b1;
                    idx_nx   = '0;
                    state_nx = READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_addr = idx;
                if (mask_q[idx]) begin
                    state_nx = WRITE;
                end else if (last_idx) begin
                    state_nx = DONE;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            WRITE: begin
                // Read data issued in the preceding READ cycle is valid now.
                busy      = 1'b1;
                mem_addr  = idx;
                mem_we    = 1'b1;
                mem_wdata = sat_sum;
                if (last_idx) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx + 1'b1;
                    state_nx = READ;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            rew_q  <= '0;
            mask_q <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (capture) begin
                rew_q  <= reward;
                mask_q <= elig_mask;
            end
        end
    end

endmodule

// File: tb/tb_reward_weight_updater.sv
`timescale 1ns/1ps
// Directed bench for reward_weight_updater with a 1-cycle-latency weight memory model.
module tb_reward_weight_updater;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DW-1:0]    reward;
    logic [DEPTH-1:0] elig_mask;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             busy;
    logic             done;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ld_vals [DEPTH];
    logic          ld_en;

    int n_cmp = 0;
    int n_err = 0;

    reward_weight_updater #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .reward    (reward),
        .elig_mask (elig_mask),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Registered-read memory, read-before-write; bulk load port for preloading.
    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ld_vals[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic load_default();
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ld_vals[i] = DW'(i * 10);
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic set_entry(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ld_vals[i] = mem[i];
        ld_vals[a] = v;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one sweep; cycle c is the cycle after edge c, start sampled at edge 0.
    task automatic run_sweep(input logic [DW-1:0] rew, input logic [DEPTH-1:0] mask,
                             input bit inject, output int done_cyc, output int n_we,
                             output int n_busy, output int n_done, output int first_wa,
                             output int last_wa, output int bad_wdata);
        done_cyc = -1; n_we = 0; n_busy = 0; n_done = 0;
        first_wa = -1; last_wa = -1; bad_wdata = 0;
        @(negedge clk);
        reward = rew; elig_mask = mask; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; reward = 8'hA5; elig_mask = 16'h5A5A;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (inject && c == 3) begin
                start = 1'b1; reward = 8'hCE; elig_mask = 16'hFFFF;
            end else if (inject && c == 4) begin
                start = 1'b0;
            end
            if (busy) n_busy++;
            if (mem_we) begin
                n_we++;
                if (first_wa < 0) first_wa = int'(mem_addr);
                last_wa = int'(mem_addr);
            end else if (mem_wdata != '0) begin
                bad_wdata++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c >= done_cyc + 2) break;
        end
        check("sweep_terminated", 32'(done_cyc > 0), 32'd1);
    endtask

    task automatic check_mem(input string tag, input int a, input int exp);
        check($sformatf("%s_mem%0d", tag, a), 32'(mem[a]), 32'(exp));
    endtask

    initial begin
        int dc, nwe, nb, nd, fwa, lwa, bw;
        rst_n = 1'b0; start = 1'b0; reward = '0; elig_mask = '0; ld_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) ld_vals[i] = '0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full mask, +5 on i*10.
        load_default();
        run_sweep(8'd5, 16'hFFFF, 1'b0, dc, nwe, nb, nd, fwa, lwa, bw);
        check("full_done_cycle", 32'(dc), 33);
        check("full_writes", 32'(nwe), 16);
        check("full_busy", 32'(nb), 32);
        check("full_done_pulses", 32'(nd), 1);
        check("full_wdata_idle0", 32'(bw), 0);
        for (int i = 0; i < DEPTH; i++) check_mem("full", i, i * 10 + 5);

        // Saturation high: 200+100 -> 255, 50+100 -> 150.
        load_default();
        set_entry(0, 8'd200);
        set_entry(1, 8'd50);
        run_sweep(8'd100, 16'h0003, 1'b0, dc, nwe, nb, nd, fwa, lwa, bw);
        check("sat_hi_done_cycle", 32'(dc), 19);
        check("sat_hi_writes", 32'(nwe), 2);
        check_mem("sat_hi", 0, 255);
        check_mem("sat_hi", 1, 150);
        for (int i = 2; i < DEPTH; i++) check_mem("sat_hi", i, i * 10);

        // Saturation low: 50-128 -> 0, 255-128 -> 127.
        set_entry(1, 8'd50);
        run_sweep(8'h80, 16'h0003, 1'b0, dc, nwe, nb, nd, fwa, lwa, bw);
        check_mem("sat_lo", 0, 127);
        check_mem("sat_lo", 1, 0);
        check_mem("sat_lo", 2, 20);
        check_mem("sat_lo", 15, 150);

        // Sparse mask, -1 on 0x80 at both ends.
        load_default();
        set_entry(0, 8'h80);
        set_entry(15, 8'h80);
        run_sweep(8'hFF, 16'h8001, 1'b0, dc, nwe, nb, nd, fwa, lwa, bw);
        check("sparse_done_cycle", 32'(dc), 19);
        check("sparse_writes", 32'(nwe), 2);
        check("sparse_first_addr", 32'(fwa), 0);
        check("sparse_last_addr", 32'(lwa), 15);
        check("sparse_busy", 32'(nb), 18);
        check_mem("sparse", 0, 8'h7F);
        check_mem("sparse", 15, 8'h7F);
        check_mem("sparse", 7, 70);

        // Empty mask.
        load_default();
        run_sweep(8'd9, 16'h0000, 1'b0, dc, nwe, nb, nd, fwa, lwa, bw);
        check("empty_done_cycle", 32'(dc), 17);
        check("empty_writes", 32'(nwe), 0);
        check("empty_busy", 32'(nb), 16);
        for (int i = 0; i < DEPTH; i += 5) check_mem("empty", i, i * 10);

        // Second start while busy is ignored: only +5 on entries 4..7.
        load_default();
        run_sweep(8'd5, 16'h00F0, 1'b1, dc, nwe, nb, nd, fwa, lwa, bw);
        check("ign_done_cycle", 32'(dc), 21);
        check("ign_writes", 32'(nwe), 4);
        check("ign_done_pulses", 32'(nd), 1);
        for (int i = 0; i < DEPTH; i++)
            check_mem("ign", i, (i >= 4 && i <= 7) ? i * 10 + 5 : i * 10);

        // Reset after the third write of a full-mask sweep.
        load_default();
        nwe = 0; nd = 0;
        @(negedge clk);
        reward = 8'd5; elig_mask = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20 && nwe < 3; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (done) nd++;
        end
        check("abort_writes_seen", 32'(nwe), 3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_we", 32'(mem_we), 0);
        check("abort_addr", 32'(mem_addr), 0);
        check("abort_wdata", 32'(mem_wdata), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (done) nd++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (done) nd++;
        end
        check("abort_total_writes", 32'(nwe), 3);
        check("abort_no_done", 32'(nd), 0);
        for (int i = 0; i < DEPTH; i++) check_mem("abort", i, (i < 3) ? i * 10 + 5 : i * 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reward_weight_updater.md
# reward_weight_updater

Read-modify-write engine that applies a signed reward delta to every eligible weight in the 16×8 synaptic weight memory. It is the bus initiator for that memory. It drives address, write enable and write data, and consumes the memory's registered read data (one-cycle latency). It sits between the reward/learning controller, which pulses `start` with a reward value and an eligibility mask, and the weight memory.

## Interface
- `DEPTH`, 16: number of weight entries; also the mask width.
- `AW`, 4: address width; `DEPTH` = 2^`AW`.
- `DW`, 8: weight width; weights are unsigned, range 0..2^`DW`-1.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only while idle.
- `reward`  in  DW  signed two's-complement delta; captured on accepted `start`.
- `elig_mask`  in  DEPTH  bit i=1 updates entry i; captured on accepted `start`.
- `mem_addr`  out  AW  weight memory address.
- `mem_we`  out  1  weight memory write enable, active high.
- `mem_wdata`  out  DW  weight memory write data.
- `mem_rdata`  in  DW  weight memory read data; holds mem[addr presented last cycle].
- `busy`  out  1  high from the cycle after an accepted `start` through the last memory access.
- `done`  out  1  one-cycle pulse after the sweep completes.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Index register `idx` (AW bits). Captured registers `rew_q` and `mask_q`.
- IDLE:
  - `busy`=0, `mem_we`=0, `mem_addr`=0.
  - On `start`=1: capture `reward` and `elig_mask`, set `idx`=0, go to READ.
- READ:
  - Drive `mem_addr`=`idx`, `mem_we`=0.
  - If `mask_q[idx]`=1: go to WRITE.
  - Else if `idx`=DEPTH-1: go to DONE.
  - Else: `idx`+1 and stay in READ.
  - A skipped entry costs one cycle and only issues a harmless read.
- WRITE:
  - `mem_rdata` now holds mem[`idx`].
  - Drive `mem_addr`=`idx`, `mem_we`=1, `mem_wdata`=sat(`mem_rdata` + `rew_q`).
  - If `idx`=DEPTH-1: go to DONE. Else: `idx`+1, go to READ.
- DONE: `done`=1 for one cycle, `busy`=0, `mem_we`=0, then return to IDLE.
- Arithmetic:
  - Zero-extend the weight and sign-extend the reward to DW+2 bits, then add.
  - Sum < 0 gives 0. Sum > 2^DW-1 gives 2^DW-1. Otherwise the sum is used unchanged.
- `reward`=0 with mask bits set still performs the writes (same value written back).
- `start` while not in IDLE (READ, WRITE, DONE) is ignored. Inputs `reward` and `elig_mask` may change freely after capture.
- `mem_addr`, `mem_we` and `mem_wdata` are combinational from state and `idx`. `mem_wdata`=0 whenever `mem_we`=0.

## Timing
- Reset (async assert, sync-to-clock release): state=IDLE, `idx`=0, `rew_q`=0, `mask_q`=0. Outputs: `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-sweep aborts immediately: no further writes and no `done` pulse. Entries already written keep their new values.
- Memory read latency is exactly 1 cycle. READ→WRITE on the same address relies on this.
- Sweep length: N = popcount(mask) and S = DEPTH-N, so memory-access cycles = 2N + S.
  - Full mask: 32 cycles.
  - Empty mask: 16 cycles.
- `done` asserts in the cycle after the last access.
- Cycle numbering: `start` sampled at edge 0, first READ in cycle 1, `done` in cycle 2N+S+1.
- A new `start` is accepted at the earliest in the cycle after `done`, i.e. when back in IDLE.

## Test plan
- Memory preloaded with mem[i]=i*10; `reward`=+5; `elig_mask`=16'hFFFF. Required: mem[i]=i*10+5, 16 writes, `busy` high 32 cycles, one `done` pulse.
- Saturation, `elig_mask`=16'h0003:
  - `reward`=+100 with mem[0]=200 → 255.
  - `reward`=-128 with mem[1]=50 → 0.
  - All other entries unchanged.
- Sparse mask 16'h8001, `reward`=-1, mem[0]=mem[15]=8'h80: both become 8'h7F. Exactly 2 cycles with `mem_we`=1 (addresses 0 and 15). `done` in cycle 19.
- `elig_mask`=0: no `mem_we` pulses, `done` in cycle 17, memory untouched.
- `start` pulsed again, with different `reward` and `elig_mask`, while `busy`: ignored. Result matches the first request only.
- `rst_n` asserted after 3 writes of a full-mask sweep: outputs return to reset values at once. Entries 0..2 are updated, 3..15 are unchanged, and no `done` pulse occurs.
